// File: rtl/ser8_pkg.sv
// Shared definitions for the 8-bit serial transmitter: FSM encoding, frame-bit
// constants and frame-length helper.
package ser8_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int unsigned DATA_BITS = 8;

  // Frame length in clock cycles: start + data + optional parity + stop.
  function automatic int unsigned frame_len(input int unsigned clks_per_bit,
                                            input bit parity_en);
    return (DATA_BITS + 2 + (parity_en ? 1 : 0)) * clks_per_bit;
  endfunction

endpackage

// File: rtl/ser8_baud.sv
// Bit-period counter: emits a one-cycle bit_tick every CLKS_PER_BIT enabled cycles.
module ser8_baud #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic bit_tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  logic [CntW-1:0] cnt_q;
  logic            last;

  assign last     = (cnt_q == CntW'(CLKS_PER_BIT - 1));
  assign bit_tick = en && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || !en || last) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ser8_tx.sv
// Byte-to-serial transmitter: start bit, 8 data bits LSB first, optional even
// parity, stop bit; valid/ready handshake on the parallel side.
module ser8_tx
  import ser8_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic       stclk,
  input  logic       strst,
  input  logic [7:0] stin,
  input  logic       stvalid,
  output logic       stready,
  output logic       stout,
  output logic       stbusy,
  output logic       stdone
);

  state_e     state_q, state_d;
  logic [7:0] sh_q;
  logic       par_q;
  logic [2:0] bit_cnt_q;
  logic       done_q;
  logic       bit_tick;
  logic       accept;

  assign accept = stvalid && stready;

  ser8_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (stclk),
    .rst     (strst),
    .clear   (accept),
    .en      (state_q != StIdle),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge stclk or posedge strst) begin
    if (strst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Parity is captured with the byte since the shift register drains it.
  always_ff @(posedge stclk or posedge strst) begin
    if (strst) begin
      sh_q      <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      if (accept) begin
        sh_q  <= stin;
        par_q <= ^stin;
      end else if (state_q == StData && bit_tick) begin
        sh_q <= {1'b0, sh_q[7:1]};
      end
      if (state_q == StData && bit_tick) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      done_q <= (state_q == StStop) && bit_tick;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StStart;
      StStart:  if (bit_tick) state_d = StData;
      StData: begin
        if (bit_tick && bit_cnt_q == 3'(DATA_BITS - 1)) begin
          state_d = PARITY_EN ? StParity : StStop;
        end
      end
      StParity: if (bit_tick) state_d = StStop;
      StStop:   if (bit_tick) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    stout   = STOP_BIT;
    stready = (state_q == StIdle);
    stbusy  = (state_q != StIdle);
    stdone  = done_q && (state_q == StIdle);
    unique case (state_q)
      StIdle:   stout = STOP_BIT;
      StStart:  stout = START_BIT;
      StData:   stout = sh_q[0];
      StParity: stout = par_q;
      StStop:   stout = STOP_BIT;
      default:  stout = STOP_BIT;
    endcase
  end

endmodule

// File: tb/tb_ser8_tx.sv
// Directed bench for ser8_tx: three instances (4 clk/bit with and without parity,
// 2 clk/bit with parity) driven from a vector table plus corner-case sequences.
module tb_ser8_tx;

  localparam int CPB [3] = '{4, 4, 2};
  localparam bit PEN [3] = '{1'b1, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din   [3];
  logic       valid [3];
  logic       ready [3];
  logic       sout  [3];
  logic       busy  [3];
  logic       done  [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ser8_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut_p4 (
    .stclk(clk), .strst(rst), .stin(din[0]), .stvalid(valid[0]),
    .stready(ready[0]), .stout(sout[0]), .stbusy(busy[0]), .stdone(done[0])
  );
  ser8_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut_n4 (
    .stclk(clk), .strst(rst), .stin(din[1]), .stvalid(valid[1]),
    .stready(ready[1]), .stout(sout[1]), .stbusy(busy[1]), .stdone(done[1])
  );
  ser8_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1'b1)) dut_p2 (
    .stclk(clk), .strst(rst), .stin(din[2]), .stvalid(valid[2]),
    .stready(ready[2]), .stout(sout[2]), .stbusy(busy[2]), .stdone(done[2])
  );

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       exp_par;
    string      name;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected level of frame bit b (0 = start).
  function automatic logic exp_bit(input int b, input logic [7:0] d, input bit pen,
                                   input logic p);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && pen) return p;
    return 1'b1;
  endfunction

  // Presents a byte (unless already presented), then checks every cycle of the frame
  // and the stdone cycle. Optionally keeps stvalid high with next_d for chaining and
  // overwrites stin with 0xFF mid-frame.
  task automatic frame(input int k, input logic [7:0] d, input logic p, input string name,
                       input bit skip_setup, input bit hold, input logic [7:0] next_d,
                       input bit mid_ff);
    int len;
    len = CPB[k] * (PEN[k] ? 11 : 10);
    if (!skip_setup) begin
      @(negedge clk);
      din[k]   = d;
      valid[k] = 1'b1;
    end
    chk({name, " ready before accept"}, 32'(ready[k]), 32'd1);
    @(posedge clk);
    for (int c = 1; c <= len + 1; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) valid[k] = 1'b0;
      if (c == 2 && hold) din[k] = next_d;
      if (c == 10 && mid_ff) din[k] = 8'hFF;
      if (c <= len) begin
        chk($sformatf("%s out c%0d", name, c), 32'(sout[k]),
            32'(exp_bit((c - 1) / CPB[k], d, PEN[k], p)));
        chk($sformatf("%s busy/ready/done c%0d", name, c),
            {29'd0, busy[k], ready[k], done[k]}, 32'b100);
      end else begin
        chk({name, " done cycle"}, {28'd0, sout[k], busy[k], ready[k], done[k]}, 32'b1011);
      end
    end
  endtask

  initial begin
    vecs[0] = '{0, 8'hA5, 1'b0, "p4 A5"};
    vecs[1] = '{0, 8'h07, 1'b1, "p4 07"};
    vecs[2] = '{0, 8'h80, 1'b1, "p4 80"};
    vecs[3] = '{0, 8'hFF, 1'b0, "p4 FF"};
    vecs[4] = '{0, 8'h6E, 1'b1, "p4 6E"};
    vecs[5] = '{1, 8'h07, 1'b1, "n4 07"};
    vecs[6] = '{1, 8'hC1, 1'b1, "n4 C1"};
    vecs[7] = '{2, 8'hFF, 1'b0, "p2 FF"};

    for (int k = 0; k < 3; k++) begin
      din[k]   = 8'h00;
      valid[k] = 1'b0;
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset state inst%0d", k),
          {28'd0, sout[k], busy[k], ready[k], done[k]}, 32'b1010);
    end
    @(negedge clk);
    @(negedge clk);
    // First byte accepted on the first edge after reset release.
    din[0]   = 8'hA5;
    valid[0] = 1'b1;
    rst      = 1'b0;
    frame(0, 8'hA5, 1'b0, "first after reset", 1'b1, 1'b0, 8'h00, 1'b0);

    foreach (vecs[i]) begin
      frame(vecs[i].inst, vecs[i].data, vecs[i].exp_par, vecs[i].name,
            1'b0, 1'b0, 8'h00, 1'b0);
    end

    // Back-to-back: 0xC3 waits on stin with stvalid high, accepted in the stdone cycle.
    frame(0, 8'h3C, 1'b0, "b2b 3C", 1'b0, 1'b1, 8'hC3, 1'b0);
    frame(0, 8'hC3, 1'b0, "b2b C3", 1'b1, 1'b0, 8'h00, 1'b0);

    // stin changes to 0xFF mid-frame; latched 0x00 must go out.
    frame(0, 8'h00, 1'b0, "mid change", 1'b0, 1'b0, 8'h00, 1'b1);

    // Reset during data bit 3 of 0xF0 (bit 3 is 0, so the line visibly returns high).
    @(negedge clk);
    din[0]   = 8'hF0;
    valid[0] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) valid[0] = 1'b0;
    end
    chk("pre-reset line low bit3", 32'(sout[0]), 32'd0);
    rst = 1'b1;
    #1;
    chk("async reset outputs", {28'd0, sout[0], busy[0], ready[0], done[0]}, 32'b1010);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("reset held c%0d", c), {28'd0, sout[0], busy[0], done[0]}, 32'b100);
    end
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done[0] !== 1'b0 || sout[0] !== 1'b1) begin
        chk("no done or retransmit after reset", {30'd0, sout[0], done[0]}, 32'b10);
      end
    end
    chk("idle after abandoned frame", {28'd0, sout[0], busy[0], ready[0], done[0]}, 32'b1010);
    frame(0, 8'h5A, 1'b0, "after mid reset", 1'b0, 1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
